// File: rtl/plic_core.sv
// plic_core: gateways, priority arbitration and claim/complete
// handshake driving one hart interrupt line.
module plic_core #(
    parameter  int NSRC   = 8,
    parameter  int PRIO_W = 5,
    localparam int IDW    = $clog2(NSRC + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NSRC-1:0]        int_src_i,
    input  logic [NSRC-1:0]        edge_mode_i,
    input  logic [NSRC-1:0]        en_i,
    input  logic [NSRC*PRIO_W-1:0] prio_i,
    input  logic [PRIO_W-1:0]      thres_i,
    input  logic                   claim_req_i,
    input  logic                   complete_req_i,
    input  logic [IDW-1:0]         complete_id_i,
    output logic [IDW-1:0]         claim_id_o,
    output logic [NSRC-1:0]        ip_o,
    output logic                   irq_o
);

    logic [NSRC-1:0] s1_q, s2_q, s3_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] insvc_q, insvc_d;
    logic [IDW-1:0]  best_id_q, best_id_d;
    logic [IDW-1:0]  claim_id_q, claim_id_d;
    logic            irq_q, irq_d;

    logic [NSRC-1:0] trig;
    logic [NSRC-1:0] gate_open;
    logic [NSRC-1:0] claim_mask;
    logic [NSRC-1:0] cmpl_mask;
    logic [NSRC-1:0] elig;
    logic [PRIO_W-1:0] best_prio;
    logic            found;
    logic            claim_fire;

    // Synchroniser chain; s3 is only used for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= int_src_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign claim_fire = claim_req_i && (best_id_q != '0);

    // Per-source trigger, gateway state and claim/complete one-hot masks
    always_comb begin
        trig       = '0;
        gate_open  = '0;
        claim_mask = '0;
        cmpl_mask  = '0;
        for (int i = 0; i < NSRC; i++) begin
            trig[i]       = edge_mode_i[i] ? (s2_q[i] & ~s3_q[i]) : s2_q[i];
            gate_open[i]  = ~pend_q[i] & ~insvc_q[i];
            claim_mask[i] = claim_fire && (best_id_q == IDW'(i + 1));
            cmpl_mask[i]  = complete_req_i && (complete_id_i == IDW'(i + 1));
        end
    end

    // Pending and in-service next state; a claim of the same ID wins
    // over a complete because that ID is not yet in service
    always_comb begin
        pend_d  = (pend_q | (gate_open & en_i & trig)) & ~claim_mask;
        insvc_d = (insvc_q & ~cmpl_mask) | claim_mask;
    end

    // Arbitration: highest priority wins, strict compare keeps lowest ID on ties
    always_comb begin
        elig      = '0;
        best_id_d = '0;
        best_prio = '0;
        found     = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            elig[i] = pend_q[i] & en_i[i] & ~claim_mask[i]
                    & (prio_i[i*PRIO_W +: PRIO_W] > thres_i);
            if (elig[i] && (!found || prio_i[i*PRIO_W +: PRIO_W] > best_prio)) begin
                found     = 1'b1;
                best_prio = prio_i[i*PRIO_W +: PRIO_W];
                best_id_d = IDW'(i + 1);
            end
        end
        irq_d = found;
    end

    // Claim result is held until the next claim strobe
    always_comb begin
        claim_id_d = claim_id_q;
        if (claim_req_i) begin
            claim_id_d = best_id_q;
        end
    end

    // Gateway, arbitration and claim state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            insvc_q    <= '0;
            best_id_q  <= '0;
            claim_id_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            insvc_q    <= insvc_d;
            best_id_q  <= best_id_d;
            claim_id_q <= claim_id_d;
            irq_q      <= irq_d;
        end
    end

    assign claim_id_o = claim_id_q;
    assign ip_o       = pend_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_plic_core.sv
// tb_plic_core: directed vectors with hand-computed expectations
// for the plic_core gateways, arbitration and claim/complete.
module tb_plic_core;

    localparam int NSRC   = 8;
    localparam int PRIO_W = 5;
    localparam int IDW    = $clog2(NSRC + 1);

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NSRC-1:0]        int_src;
    logic [NSRC-1:0]        edge_mode;
    logic [NSRC-1:0]        en;
    logic [NSRC*PRIO_W-1:0] prio;
    logic [PRIO_W-1:0]      thres;
    logic                   claim_req;
    logic                   complete_req;
    logic [IDW-1:0]         complete_id;
    logic [IDW-1:0]         claim_id;
    logic [NSRC-1:0]        ip;
    logic                   irq;

    int n_cmp = 0;
    int n_err = 0;

    plic_core #(.NSRC(NSRC), .PRIO_W(PRIO_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .int_src_i     (int_src),
        .edge_mode_i   (edge_mode),
        .en_i          (en),
        .prio_i        (prio),
        .thres_i       (thres),
        .claim_req_i   (claim_req),
        .complete_req_i(complete_req),
        .complete_id_i (complete_id),
        .claim_id_o    (claim_id),
        .ip_o          (ip),
        .irq_o         (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_prio(input int id, input logic [PRIO_W-1:0] p);
        prio[(id-1)*PRIO_W +: PRIO_W] = p;
    endtask

    task automatic pulse(input logic [NSRC-1:0] m);
        int_src = int_src | m;
        step();
        int_src = int_src & ~m;
    endtask

    task automatic claim();
        claim_req = 1'b1;
        step();
        claim_req = 1'b0;
    endtask

    task automatic complete(input int id);
        complete_req = 1'b1;
        complete_id  = IDW'(id);
        step();
        complete_req = 1'b0;
        complete_id  = '0;
    endtask

    initial begin
        rst          = 1'b1;
        int_src      = '0;
        edge_mode    = '0;
        en           = '1;
        prio         = '0;
        thres        = 5'd1;
        claim_req    = 1'b0;
        complete_req = 1'b0;
        complete_id  = '0;
        steps(2);
        check("rst_ip", 32'(ip), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_claim", 32'(claim_id), 32'h0);
        rst = 1'b0;

        // Level source ID 3, prio 4
        set_prio(3, 5'd4);
        int_src[2] = 1'b1;
        steps(2);
        check("lvl_ip_e2", 32'(ip), 32'h00);
        step();
        check("lvl_ip_e3", 32'(ip), 32'h04);
        check("lvl_irq_e3", 32'(irq), 32'h0);
        step();
        check("lvl_irq_e4", 32'(irq), 32'h1);
        claim();
        check("lvl_claim", 32'(claim_id), 32'h3);
        check("lvl_ip_clm", 32'(ip), 32'h00);
        check("lvl_irq_clm", 32'(irq), 32'h0);
        step();
        check("lvl_ip_svc", 32'(ip), 32'h00);
        complete(3);
        check("lvl_ip_cmp", 32'(ip), 32'h00);
        step();
        check("lvl_repend", 32'(ip), 32'h04);
        check("lvl_irq_rp0", 32'(irq), 32'h0);
        step();
        check("lvl_irq_rp1", 32'(irq), 32'h1);
        int_src[2] = 1'b0;
        claim();
        check("lvl_claim2", 32'(claim_id), 32'h3);
        complete(3);
        steps(4);
        check("lvl_clean", 32'(ip), 32'h00);

        // Edge sources ID 2 and ID 5, equal prio 7
        edge_mode[1] = 1'b1;
        edge_mode[4] = 1'b1;
        set_prio(2, 5'd7);
        set_prio(5, 5'd7);
        pulse(8'h12);
        steps(4);
        check("tie_ip", 32'(ip), 32'h12);
        check("tie_irq", 32'(irq), 32'h1);
        claim();
        check("tie_claim1", 32'(claim_id), 32'h2);
        check("tie_irq1", 32'(irq), 32'h1);
        check("tie_ip1", 32'(ip), 32'h10);
        claim();
        check("tie_claim2", 32'(claim_id), 32'h5);
        check("tie_irq2", 32'(irq), 32'h0);
        claim();
        check("tie_claim3", 32'(claim_id), 32'h0);
        complete(2);
        complete(5);
        step();
        check("tie_clean", 32'(ip), 32'h00);

        // Edge source ID 1: re-pulse while in service is dropped
        edge_mode[0] = 1'b1;
        set_prio(1, 5'd2);
        pulse(8'h01);
        steps(4);
        claim();
        check("e1_claim", 32'(claim_id), 32'h1);
        pulse(8'h01);
        steps(4);
        check("e1_drop_ip", 32'(ip), 32'h00);
        check("e1_drop_irq", 32'(irq), 32'h0);
        complete(1);
        steps(4);
        check("e1_no_late", 32'(ip), 32'h00);
        pulse(8'h01);
        steps(4);
        check("e1_repend", 32'(ip), 32'h01);
        check("e1_irq", 32'(irq), 32'h1);
        claim();
        complete(1);

        // Threshold versus priority, level source ID 4
        set_prio(4, 5'd3);
        thres = 5'd3;
        int_src[3] = 1'b1;
        steps(5);
        check("thr_ip", 32'(ip), 32'h08);
        check("thr_eq", 32'(irq), 32'h0);
        thres = 5'd2;
        step();
        check("thr_lower", 32'(irq), 32'h1);
        set_prio(4, 5'd0);
        step();
        check("prio0", 32'(irq), 32'h0);
        thres = 5'd0;
        steps(2);
        check("prio0_thr0", 32'(irq), 32'h0);
        int_src[3] = 1'b0;
        set_prio(4, 5'd3);
        steps(2);
        claim();
        check("thr_claim", 32'(claim_id), 32'h4);
        complete(4);
        thres = 5'd1;
        steps(4);
        check("thr_clean", 32'(ip), 32'h00);

        // Ignored completes, then claim+complete in one cycle
        pulse(8'h02);
        steps(4);
        claim();
        check("cmp_claim2", 32'(claim_id), 32'h2);
        complete(0);
        complete(NSRC + 1);
        complete(1);
        pulse(8'h02);
        steps(4);
        check("cmp_still_svc", 32'(ip), 32'h00);
        pulse(8'h01);
        steps(4);
        check("cmp_ip1", 32'(ip), 32'h01);
        complete_req = 1'b1;
        complete_id  = IDW'(2);
        claim();
        complete_req = 1'b0;
        complete_id  = '0;
        check("both_claim", 32'(claim_id), 32'h1);
        check("both_ip", 32'(ip), 32'h00);
        pulse(8'h02);
        steps(4);
        check("both_freed", 32'(ip), 32'h02);
        check("both_irq", 32'(irq), 32'h1);

        // Reset with ID 1,2 in service and ID 3,4,6 pending
        claim();
        check("rst_pre_claim", 32'(claim_id), 32'h2);
        edge_mode[5] = 1'b0;
        set_prio(6, 5'd1);
        int_src = 8'h2C;
        steps(4);
        check("rst_pre_ip", 32'(ip), 32'h2C);
        check("rst_pre_irq", 32'(irq), 32'h1);
        int_src = 8'h04;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_ip", 32'(ip), 32'h00);
        check("mid_rst_irq", 32'(irq), 32'h0);
        check("mid_rst_claim", 32'(claim_id), 32'h0);
        steps(2);
        check("post_rst_e2", 32'(ip), 32'h00);
        step();
        check("post_rst_e3", 32'(ip), 32'h04);
        pulse(8'h02);
        steps(4);
        check("post_rst_svc", 32'(ip), 32'h06);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
